mem_port_arbiter: RTL

- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores with byte enables).
- Grants one outstanding transaction at a time and drives the memory request handshake.
- Returns read data and a one-cycle done pulse to the owning requester, and generates per-port stall signals for the hazard logic.
- Data port has default priority; an anti-starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// data (load/store) stage. One transaction in flight at a time; data has
// default priority and a starvation counter forces a fetch grant eventually.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   // fetch requester
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   // data requester
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_done,
   // memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   // hazard / status
   output logic                stall_if,
   output logic                stall_dm,
   output logic                busy
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } stateT;

   stateT      state;
   stateT      stateNext;
   logic       ownerData;
   logic [3:0] starveCnt;
   logic       ifElig;
   logic       dmElig;
   logic       grantIf;
   logic       grantDm;

   // A request whose done is high this cycle has just been served and is not new.
   assign ifElig   = if_req & ~if_done;
   assign dmElig   = dm_req & ~dm_done;

   assign stall_if = if_req & ~if_done;
   assign stall_dm = dm_req & ~dm_done;
   assign busy     = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // Next-state and grant decision; fetch only overrides data once starved.
   always_comb begin
      stateNext = state;
      grantIf   = 1'b0;
      grantDm   = 1'b0;
      unique case (state)
         IDLE: begin
            if (dmElig && !(ifElig && (starveCnt == STARVE_LIM))) begin
               grantDm   = 1'b1;
               stateNext = ISSUE;
            end else if (ifElig) begin
               grantIf   = 1'b1;
               stateNext = ISSUE;
            end
         end
         ISSUE:   if (mem_ready)  stateNext = WAIT;
         WAIT:    if (mem_rvalid) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Latch the winning request, track starvation, and return data/done to the owner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ownerData <= 1'b0;
         starveCnt <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_done   <= 1'b0;
         dm_done   <= 1'b0;
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;

         if (grantDm) begin
            ownerData <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            if (ifElig && (starveCnt != STARVE_LIM)) starveCnt <= starveCnt + 4'd1;
         end else if (grantIf) begin
            ownerData <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            starveCnt <= '0;
         end

         if ((state == ISSUE) && mem_ready) mem_req <= 1'b0;

         if ((state == WAIT) && mem_rvalid) begin
            if (ownerData) begin
               dm_done <= 1'b1;
               if (!mem_we) dm_rdata <= mem_rdata;
            end else begin
               if_done  <= 1'b1;
               if_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule
